// File: rtl/vga_line_prefetch.sv
// Double-buffered line prefetcher feeding the VGA controller's pixel input.
// Line N+1 is fetched into one bank over req/ack while line N is shown from the other.
module vga_line_prefetch #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              vga_clk,
  input  logic              clrn,
  input  logic [10:0]       col_addr,
  input  logic [10:0]       row_addr,
  output logic [11:0]       d_out,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [11:0]       mem_data,
  output logic              busy,
  output logic              underrun
);

  localparam int                IDX_W      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [10:0]       H_LIM      = 11'(H_ACTIVE);
  localparam logic [10:0]       V_LIM      = 11'(V_ACTIVE);
  localparam logic [10:0]       X_LAST     = 11'(H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state, state_d;
  logic [10:0]       prev_row;
  logic [10:0]       target, target_d;
  logic [10:0]       pending, pending_d;
  logic [10:0]       x, x_d;
  logic [ADDR_W-1:0] line_base, line_base_d;
  logic              frame_valid, frame_valid_d;
  logic              underrun_d;
  logic              wr_en;
  logic              trig_go;
  logic [10:0]       trig_line;
  logic [10:0]       restart_line;
  logic [11:0]       bank [2][H_ACTIVE];

  function automatic logic [ADDR_W-1:0] base_of(input logic [10:0] line);
    return ADDR_W'(line) * LINE_WORDS;
  endfunction

  // A row change requests the next line; entering vblank requests line 0.
  always_comb begin
    trig_go   = 1'b0;
    trig_line = '0;
    if (row_addr != prev_row) begin
      if (row_addr == V_LIM) begin
        trig_go = 1'b1;
      end else if ({1'b0, row_addr} + 12'd1 < {1'b0, V_LIM}) begin
        trig_go   = 1'b1;
        trig_line = row_addr + 11'd1;
      end
    end
  end

  assign restart_line = trig_go ? trig_line : pending;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d       = state;
    target_d      = target;
    pending_d     = pending;
    x_d           = x;
    line_base_d   = line_base;
    frame_valid_d = frame_valid;
    underrun_d    = underrun;
    wr_en         = 1'b0;
    case (state)
      IDLE: begin
        if (trig_go) begin
          state_d     = FETCH;
          target_d    = trig_line;
          x_d         = '0;
          line_base_d = base_of(trig_line);
        end
      end
      FETCH: begin
        if (trig_go) begin
          underrun_d = 1'b1;
          if (mem_ack) begin
            target_d    = trig_line;
            x_d         = '0;
            line_base_d = base_of(trig_line);
          end else begin
            pending_d = trig_line;
            state_d   = DRAIN;
          end
        end else if (mem_ack) begin
          wr_en = 1'b1;
          if (x == X_LAST) begin
            state_d = IDLE;
            if (target == '0) frame_valid_d = 1'b1;
          end else begin
            x_d = x + 11'd1;
          end
        end
      end
      DRAIN: begin
        // The outstanding request must complete before the address may move.
        if (trig_go) begin
          underrun_d = 1'b1;
          pending_d  = trig_line;
        end
        if (mem_ack) begin
          state_d     = FETCH;
          target_d    = restart_line;
          x_d         = '0;
          line_base_d = base_of(restart_line);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      prev_row    <= '0;
      target      <= '0;
      pending     <= '0;
      x           <= '0;
      line_base   <= '0;
      frame_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_d;
      prev_row    <= row_addr;
      target      <= target_d;
      pending     <= pending_d;
      x           <= x_d;
      line_base   <= line_base_d;
      frame_valid <= frame_valid_d;
      underrun    <= underrun_d;
    end
  end

  // NOTE: line banks carry no reset; frame_valid gates their output until written.
  always_ff @(posedge vga_clk) begin
    if (wr_en) bank[target[0]][x[IDX_W-1:0]] <= mem_data;
  end

  always_comb begin
    d_out = '0;
    if (frame_valid && (row_addr < V_LIM) && (col_addr < H_LIM))
      d_out = bank[row_addr[0]][col_addr[IDX_W-1:0]];
  end

  assign mem_req  = (state != IDLE);
  assign busy     = (state == FETCH);
  assign mem_addr = line_base + ADDR_W'(x);

endmodule
